packed_add_pipe: RTL and testbench

Pipelined, parametrised partitioned adder/subtractor for the M16 datapath. It splits an N-slice word into lanes of 1, 2, 4, … slices, chains carries inside each lane and breaks them at lane boundaries. It applies per-lane signed or unsigned saturation and records sticky per-lane overflow status. It has a valid/ready handshake, 2-cycle latency and full throughput, and replaces the combinational carry/saturation control of the previous generation.

---
 rtl/packed_add_pkg.sv | 34 +++
 rtl/packed_add_pipe_slice_adder.sv | 26 ++
 rtl/packed_add_pipe.sv | 196 +++++++++++++++++++
 tb/tb_packed_add_pipe.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packed_add_pkg.sv
// Shared width codes and lane/saturation helpers for the partitioned adder pipeline.
package packed_add_pkg;

  localparam int unsigned W_SLICE   = 0;
  localparam int unsigned W_PAIR    = 1;
  localparam int unsigned W_QUAD    = 2;

  localparam int unsigned SAT_MAX_W = 32;
  localparam int unsigned SAT_IDX_W = $clog2(SAT_MAX_W);

  // True when slice i is the lowest slice of a lane spanning 2^width slices.
  function automatic logic lane_start(input int unsigned i, input int unsigned width);
    int unsigned mask;
    mask = (32'd1 << width) - 32'd1;
    return (i & mask) == 32'd0;
  endfunction

  // Saturation pattern for the top slice of an overflowing lane, in the low slice_w bits.
  // The lower slices of the lane take the replicated fill bit (bit 0 of this pattern).
  function automatic logic [SAT_MAX_W-1:0] sat_value(input logic        sign,
                                                     input logic        sub,
                                                     input logic        msb_a,
                                                     input int unsigned slice_w);
    logic                 fill;
    logic [SAT_MAX_W-1:0] v;
    fill = sign ? ~msb_a : ~sub;
    v    = fill ? ((SAT_MAX_W'(1) << slice_w) - SAT_MAX_W'(1)) : '0;
    if (sign) begin
      v[SAT_IDX_W'(slice_w - 32'd1)] = msb_a;
    end
    return v;
  endfunction

endpackage

// File: rtl/packed_add_pipe_slice_adder.sv
// One SLICE_W-bit ripple slice; exposes carry-out and the carry into its MSB.
module slice_adder
  import packed_add_pkg::*;
#(
  parameter int unsigned SLICE_W = 4  // must be >= 2
) (
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_sum,
  output logic               o_cout,
  output logic               o_cmsb
);

  logic [SLICE_W-1:0] w_low;
  logic [1:0]         w_msb;

  // Bits below the MSB, with their carry landing in the top bit of w_low.
  assign w_low  = {1'b0, i_a[SLICE_W-2:0]} + {1'b0, i_b[SLICE_W-2:0]} + SLICE_W'(i_cin);
  assign w_msb  = 2'(i_a[SLICE_W-1]) + 2'(i_b[SLICE_W-1]) + 2'(w_low[SLICE_W-1]);

  assign o_sum  = {w_msb[0], w_low[SLICE_W-2:0]};
  assign o_cout = w_msb[1];
  assign o_cmsb = w_low[SLICE_W-1];

endmodule

// File: rtl/packed_add_pipe.sv
// Two-stage partitioned add/sub with per-lane saturation and overflow flags.
// Optional sticky overflow accumulation under `PACKED_ADD_STICKY_EN.
module packed_add_pipe
  import packed_add_pkg::*;
#(
  parameter  int unsigned NUM_SLICES = 4,
  parameter  int unsigned SLICE_W    = 4,
  localparam int unsigned W          = NUM_SLICES * SLICE_W,
  localparam int unsigned WC_W       = $clog2(NUM_SLICES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          a,
  input  logic [W-1:0]          b,
  input  logic [WC_W-1:0]       width,
  input  logic                  sub,
  input  logic                  sign,
  input  logic                  saturate,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          result,
  output logic [NUM_SLICES-1:0] ovf,
  output logic [NUM_SLICES-1:0] sticky_ovf,
  input  logic                  flag_clr
);

  localparam int unsigned LOG2_N = WC_W;

  logic                  w_en;
  logic [W-1:0]          w_b_eff;
  int unsigned           w_width_eff;
  logic [W-1:0]          w_sum_all;
  logic [NUM_SLICES-1:0] w_cout_all;
  logic [NUM_SLICES-1:0] w_cmsb_all;
  logic [NUM_SLICES-1:0] w_top;
  logic [NUM_SLICES-1:0] w_amsb;

  logic                  r1_valid;
  logic [W-1:0]          r1_sum;
  logic [NUM_SLICES-1:0] r1_cout;
  logic [NUM_SLICES-1:0] r1_cmsb;
  logic [NUM_SLICES-1:0] r1_top;
  logic [NUM_SLICES-1:0] r1_amsb;
  logic                  r1_sub;
  logic                  r1_sign;
  logic                  r1_sat;

  logic [W-1:0]          w_result;
  logic [NUM_SLICES-1:0] w_ovf;

  logic                  r2_valid;
  logic [W-1:0]          r2_result;
  logic [NUM_SLICES-1:0] r2_ovf;

  assign w_en     = !r2_valid || out_ready;
  assign in_ready = w_en;
  assign w_b_eff  = sub ? ~b : b;

  // Codes wider than the word collapse to one full-word lane.
  always_comb begin
    w_width_eff = 32'(width);
    if (w_width_eff > LOG2_N - 32'd1) begin
      w_width_eff = LOG2_N;
    end
  end

  for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
    logic               w_cin;
    logic               w_cout;
    logic               w_cmsb;
    logic [SLICE_W-1:0] w_sum;

    // Carry enters fresh at a lane boundary, otherwise ripples from the slice below.
    if (gi == 0) begin : g_first
      assign w_cin = sub;
    end else begin : g_rest
      assign w_cin = lane_start(gi, w_width_eff) ? sub : g_slice[gi-1].w_cout;
    end

    if (gi == NUM_SLICES - 1) begin : g_hi
      assign w_top[gi] = 1'b1;
    end else begin : g_lo
      assign w_top[gi] = lane_start(gi + 1, w_width_eff);
    end

    slice_adder #(.SLICE_W(SLICE_W)) u_slice (
      .i_a    (a[gi*SLICE_W +: SLICE_W]),
      .i_b    (w_b_eff[gi*SLICE_W +: SLICE_W]),
      .i_cin  (w_cin),
      .o_sum  (w_sum),
      .o_cout (w_cout),
      .o_cmsb (w_cmsb)
    );

    assign w_sum_all[gi*SLICE_W +: SLICE_W] = w_sum;
    assign w_cout_all[gi]                   = w_cout;
    assign w_cmsb_all[gi]                   = w_cmsb;
    assign w_amsb[gi]                       = a[gi*SLICE_W + SLICE_W - 1];
  end

  // Stage 1: raw per-slice sums, carries and lane control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_sum   <= '0;
      r1_cout  <= '0;
      r1_cmsb  <= '0;
      r1_top   <= '0;
      r1_amsb  <= '0;
      r1_sub   <= 1'b0;
      r1_sign  <= 1'b0;
      r1_sat   <= 1'b0;
    end else if (w_en) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_sum  <= w_sum_all;
        r1_cout <= w_cout_all;
        r1_cmsb <= w_cmsb_all;
        r1_top  <= w_top;
        r1_amsb <= w_amsb;
        r1_sub  <= sub;
        r1_sign <= sign;
        r1_sat  <= saturate;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_sat
    logic               w_raw;
    logic               w_lane_ovf;
    logic               w_lane_amsb;
    logic               w_fill;
    logic [SLICE_W-1:0] w_sat_val;

    assign w_raw = r1_sign ? (r1_cmsb[gi] ^ r1_cout[gi]) : (r1_cout[gi] ^ r1_sub);

    // Lane verdict and a's lane MSB propagate down from the lane's top slice.
    if (gi == NUM_SLICES - 1) begin : g_hi
      assign w_lane_ovf  = w_raw;
      assign w_lane_amsb = r1_amsb[gi];
    end else begin : g_lo
      assign w_lane_ovf  = r1_top[gi] ? w_raw       : g_sat[gi+1].w_lane_ovf;
      assign w_lane_amsb = r1_top[gi] ? r1_amsb[gi] : g_sat[gi+1].w_lane_amsb;
    end

    assign w_fill    = r1_sign ? ~w_lane_amsb : ~r1_sub;
    assign w_sat_val = r1_top[gi] ? SLICE_W'(sat_value(r1_sign, r1_sub, w_lane_amsb, SLICE_W))
                                  : {SLICE_W{w_fill}};

    assign w_ovf[gi] = r1_top[gi] & w_raw;
    assign w_result[gi*SLICE_W +: SLICE_W] = (r1_sat && w_lane_ovf) ? w_sat_val
                                                                    : r1_sum[gi*SLICE_W +: SLICE_W];
  end

  // Stage 2: final result and overflow flags, held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid  <= 1'b0;
      r2_result <= '0;
      r2_ovf    <= '0;
    end else if (w_en) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_result <= w_result;
        r2_ovf    <= w_ovf;
      end
    end
  end

  assign out_valid = r2_valid;
  assign result    = r2_result;
  assign ovf       = r2_ovf;

`ifdef PACKED_ADD_STICKY_EN
  logic [NUM_SLICES-1:0] r_sticky;

  // Clear drops old bits; flags from a concurrent handshake still land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= (flag_clr ? '0 : r_sticky) | ((r2_valid && out_ready) ? r2_ovf : '0);
    end
  end

  assign sticky_ovf = r_sticky;
`else
  logic w_unused_flag_clr;

  assign w_unused_flag_clr = flag_clr;
  assign sticky_ovf        = '0;
`endif

endmodule

// File: tb/tb_packed_add_pipe.sv
// Scoreboard bench for packed_add_pipe: lane-arithmetic reference model, random and directed beats.
module tb_packed_add_pipe;
  import packed_add_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned SW = 4;
  localparam int unsigned W  = N * SW;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   width = 2'd0;
  logic         sub = 1'b0;
  logic         sign = 1'b0;
  logic         saturate = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic [N-1:0] ovf;
  logic [N-1:0] sticky_ovf;
  logic         flag_clr = 1'b0;

  typedef struct {
    logic [W-1:0] res;
    logic [N-1:0] ovf;
    bit           lat;
    int           t;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         m_e;
  logic [N-1:0] m_set;
  logic [N-1:0] sticky_exp = '0;
  bit           hold_v = 1'b0;
  logic [W-1:0] hold_res = '0;
  logic [N-1:0] hold_ovf = '0;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  bit           done = 1'b0;

  packed_add_pipe #(.NUM_SLICES(N), .SLICE_W(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .width      (width),
    .sub        (sub),
    .sign       (sign),
    .saturate   (saturate),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .ovf        (ovf),
    .sticky_ovf (sticky_ovf),
    .flag_clr   (flag_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Lane-level reference: integer arithmetic per lane, range test, then wrap or clamp.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic [1:0] mw, input logic msub, input logic msign,
                                input logic msat, output logic [W-1:0] mres,
                                output logic [N-1:0] movf);
    int     slices;
    int     lw;
    longint mask, half, ua, ub, sa, sb, s, r;
    bit     ov;
    slices = (mw >= 2'd2) ? 4 : (1 << mw);
    lw     = slices * SW;
    mask   = (64'(1) << lw) - 1;
    half   = 64'(1) << (lw - 1);
    mres   = '0;
    movf   = '0;
    for (int base = 0; base < int'(W); base += lw) begin
      ua = (64'(ma) >> base) & mask;
      ub = (64'(mb) >> base) & mask;
      sa = (ua >= half) ? ua - (mask + 1) : ua;
      sb = (ub >= half) ? ub - (mask + 1) : ub;
      if (msign) begin
        s  = msub ? sa - sb : sa + sb;
        ov = (s > half - 1) || (s < -half);
      end else begin
        s  = msub ? ua - ub : ua + ub;
        ov = (s > mask) || (s < 0);
      end
      r = s & mask;
      if (msat && ov) begin
        if (msign) r = (sa >= 0) ? half - 1 : half;
        else       r = msub ? 64'(0) : mask;
      end
      mres = mres | W'(r << base);
      if (ov) movf[(base + lw) / int'(SW) - 1] = 1'b1;
    end
  endfunction

  // Present a beat at a falling edge and wait (bounded) until it will be accepted.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic [1:0] tw,
                      input logic ts, input logic tg, input logic tt, input bit use_model,
                      input logic [W-1:0] xres, input logic [N-1:0] xovf, input bit lat);
    exp_t e;
    int   waited;
    @(negedge clk);
    a = ta; b = tbv; width = tw; sub = ts; sign = tg; saturate = tt; in_valid = 1'b1;
    if (use_model) begin
      model(ta, tbv, tw, ts, tg, tt, e.res, e.ovf);
    end else begin
      e.res = xres;
      e.ovf = xovf;
    end
    e.lat  = lat;
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end else begin
      e.t = cyc;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: stall stability, in-order scoreboard compare, sticky tracking.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v     = 1'b0;
      sticky_exp = '0;
    end else begin
      check("sticky_ovf", 32'(sticky_ovf), 32'(sticky_exp));
      if (hold_v) begin
        check("hold_result", 32'(result), 32'(hold_res));
        check("hold_ovf", 32'(ovf), 32'(hold_ovf));
      end
      hold_v   = out_valid && !out_ready;
      hold_res = result;
      hold_ovf = ovf;
      m_set    = '0;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected no beat", result);
        end else begin
          m_e = sb_q.pop_front();
          check("result", 32'(result), 32'(m_e.res));
          check("ovf", 32'(ovf), 32'(m_e.ovf));
          if (m_e.lat) check("latency", 32'(cyc - m_e.t), 32'd2);
          m_set = m_e.ovf;
        end
      end
`ifdef PACKED_ADD_STICKY_EN
      sticky_exp = (flag_clr ? 4'b0 : sticky_exp) | m_set;
`endif
    end
  end

  initial begin
    logic [W-1:0] sa_v [4];
    logic [W-1:0] sb_v [4];
    logic [1:0]   sw_v [4];
    logic [2:0]   sc_v [4];
    logic [W-1:0] tmp_res;
    logic [N-1:0] tmp_ovf;
    logic [N-1:0] stall_or;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_sticky", 32'(sticky_ovf), 32'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Directed corner beats with literal expectations and a latency check.
    send(16'hFFFF, 16'h0001, 2'(W_QUAD), 0, 0, 0, 0, 16'h0000, 4'b1000, 1); idle(); drain();
    send(16'hFFFF, 16'h0001, 2'(W_QUAD), 0, 0, 1, 0, 16'hFFFF, 4'b1000, 1); idle(); drain();
    send(16'h7777, 16'h1111, 2'(W_SLICE), 0, 1, 1, 0, 16'h7777, 4'b1111, 1); idle(); drain();
    send(16'h7777, 16'h1111, 2'(W_SLICE), 0, 0, 1, 0, 16'h8888, 4'b0000, 1); idle(); drain();
    send(16'h8000, 16'h0100, 2'(W_PAIR), 1, 1, 1, 0, 16'h8000, 4'b1000, 1); idle(); drain();
    send(16'h0000, 16'h0001, 2'(W_PAIR), 1, 1, 1, 0, 16'h00FF, 4'b0000, 1); idle(); drain();
    send(16'h00FF, 16'h0001, 2'd3, 0, 0, 0, 0, 16'h0100, 4'b0000, 1); idle(); drain();
    send(16'h0001, 16'h0002, 2'd3, 1, 0, 1, 0, 16'h0000, 4'b1000, 1); idle(); drain();

    // Backpressure: four back-to-back beats against a stalled output.
    @(posedge clk); #1 out_ready = 1'b0; flag_clr = 1'b1;
    @(posedge clk); #1 flag_clr = 1'b0;
    stall_or = '0;
    for (int k = 0; k < 4; k++) begin
      sa_v[k] = W'($urandom);
      sb_v[k] = W'($urandom);
      sw_v[k] = 2'($urandom_range(0, 3));
      sc_v[k] = 3'($urandom_range(0, 7));
      model(sa_v[k], sb_v[k], sw_v[k], sc_v[k][0], sc_v[k][1], sc_v[k][2], tmp_res, tmp_ovf);
      stall_or = stall_or | tmp_ovf;
    end
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          send(sa_v[k], sb_v[k], sw_v[k], sc_v[k][0], sc_v[k][1], sc_v[k][2], 1, '0, '0, 0);
        end
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        check("in_ready_stalled", 32'(in_ready), 32'd0);
        check("out_valid_stalled", 32'(out_valid), 32'd1);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();
`ifdef PACKED_ADD_STICKY_EN
    check("sticky_after_stall", 32'(sticky_ovf), 32'(stall_or));
`else
    check("sticky_after_stall", 32'(sticky_ovf), 32'd0);
`endif

    // Random traffic with random backpressure and occasional sticky clears.
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          if ($urandom_range(0, 3) == 0) idle();
          send(W'($urandom), W'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
               1'($urandom), 1'($urandom), 1, '0, '0, 0);
        end
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
          flag_clr  = ($urandom_range(0, 19) == 0);
        end
        out_ready = 1'b1;
        flag_clr  = 1'b0;
      end
    join
    drain();

    // Reset with two beats in flight: everything in the pipe must vanish.
    send(16'hFFFF, 16'hFFFF, 2'd0, 0, 0, 0, 1, '0, '0, 0);
    send(16'h7FFF, 16'h0001, 2'd2, 0, 1, 1, 1, '0, '0, 0);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sticky", 32'(sticky_ovf), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    #1;
    check("in_ready_after_midrst", 32'(in_ready), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("no_stale_output", 32'(out_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
